// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the VGA output path. It keeps a horizontal
//   pixel counter (hc) and a vertical line counter (vc) and decodes sync,
//   blank and start pulses from them.
//
//   DrawX/DrawY come straight from the counter flops. Every other output is
//   decoded from the *next* counter value and then registered, so all
//   outputs change on the same rising edge and describe the same pixel.
//   Sprite blocks can therefore sample DrawX/DrawY/blank on the falling edge
//   and rely on them being stable for a full vga_clk period.
//
// Ports
//   vga_clk      in   pixel clock, all state on the rising edge
//   reset_n      in   asynchronous active-low reset
//   hs, vs       out  registered sync outputs (active level HS_POL/VS_POL)
//   blank        out  1 = visible pixel
//   DrawX, DrawY out  current column / line
//   line_start   out  1-cycle pulse while DrawX == 0
//   frame_start  out  1-cycle pulse while DrawX == 0 and DrawY == 0
//   frame_count  out  frames started since reset, wraps 255 -> 0
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Decode boundaries, pre-sized to the counter width.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Registered decode bundle; updated together so there is no skew.
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
    logic line_start;
    logic frame_start;
  } raster_t;

  // Reset describes the last pixel of the frame, so the first edge after
  // release lands naturally on (0,0) with the frame pulses.
  localparam raster_t RASTER_RST = '{
    blank:       1'b0,
    hs:          ~HS_POL,
    vs:          ~VS_POL,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic [9:0] hc, vc;
  logic [9:0] hc_nxt, vc_nxt;
  logic       h_wrap;
  raster_t    rst_q, rst_nxt;
  logic [7:0] fc_q;

  // ---------------------------------------------------------------------
  // Next-state counters
  // ---------------------------------------------------------------------
  always_comb begin
    h_wrap = (hc == H_LAST);
    hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
    vc_nxt = vc;
    if (h_wrap)
      vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
  end

  // ---------------------------------------------------------------------
  // Decode of the position the counters move to on this edge
  // ---------------------------------------------------------------------
  always_comb begin
    rst_nxt             = RASTER_RST;
    rst_nxt.blank       = (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
    rst_nxt.hs          = ((hc_nxt >= HS_BEGIN) && (hc_nxt < HS_END))
                          ? HS_POL : ~HS_POL;
    // vs covers every pixel of the sync lines, independent of hc.
    rst_nxt.vs          = ((vc_nxt >= VS_BEGIN) && (vc_nxt < VS_END))
                          ? VS_POL : ~VS_POL;
    rst_nxt.line_start  = (hc_nxt == 10'd0);
    rst_nxt.frame_start = (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc    <= H_LAST;
      vc    <= V_LAST;
      rst_q <= RASTER_RST;
      fc_q  <= 8'd0;
    end else begin
      hc    <= hc_nxt;
      vc    <= vc_nxt;
      rst_q <= rst_nxt;
      // Counts on the same edge that raises frame_start; wraps naturally.
      if (rst_nxt.frame_start)
        fc_q <= fc_q + 8'd1;
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = rst_q.blank;
  assign hs          = rst_q.hs;
  assign vs          = rst_q.vs;
  assign line_start  = rst_q.line_start;
  assign frame_start = rst_q.frame_start;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so that 256 frames fit in
// a short run. A reference model of the raster position pushes the expected
// output bundle into a queue before each clock edge; the DUT outputs are
// popped and compared #1 after the edge.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam bit HP = 1'b0, VP = 1'b0;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 11
  localparam int FT = HT * VT;             // 165

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hs, vs, blank, line_start, frame_start;
  logic [9:0] DrawX, DrawY;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .hs(hs), .vs(vs), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  obs_t dut_o;
  assign dut_o = {DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count};

  int   n_chk = 0;
  int   n_fail = 0;
  obs_t sb_q[$];

  // reference model state
  int   mx, my;
  logic [7:0] mfc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.x     = 10'(mx);
    o.y     = 10'(my);
    o.blank = (mx < HV) && (my < VV);
    o.hs    = (mx >= HV + HF && mx < HV + HF + HS) ? HP : ~HP;
    o.vs    = (my >= VV + VF && my < VV + VF + VS) ? VP : ~VP;
    o.ls    = (mx == 0) && (mfc != 8'd0 || my != VT - 1 || 1'b1) && !(mx == HT - 1);
    o.ls    = (mx == 0);
    o.fs    = (mx == 0) && (my == 0);
    o.fc    = mfc;
    return o;
  endfunction

  function automatic obs_t reset_out();
    obs_t o;
    o.x = 10'(HT - 1); o.y = 10'(VT - 1);
    o.blank = 1'b0; o.hs = ~HP; o.vs = ~VP;
    o.ls = 1'b0; o.fs = 1'b0; o.fc = 8'd0;
    return o;
  endfunction

  task automatic model_reset();
    mx = HT - 1; my = VT - 1; mfc = 8'd0;
    sb_q.delete();
  endtask

  // One clock: advance the model, queue its prediction, compare after edge.
  task automatic step();
    obs_t e;
    if (mx == HT - 1) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    if (mx == 0 && my == 0) mfc = mfc + 8'd1;
    sb_q.push_back(model_out());
    @(posedge vga_clk);
    #1;
    e = sb_q.pop_front();
    chk("raster", 64'(dut_o), 64'(e));
  endtask

  initial begin
    int n_blank, n_hs, n_vs, n_ls, n_fs, first_vs, fs_seen, guard;

    // ---------------- reset hold ----------------
    model_reset();
    repeat (5) @(posedge vga_clk);
    #1;
    chk("rst_state", 64'(dut_o), 64'(reset_out()));
    chk("rst_hs", 64'(hs), 64'(1));
    chk("rst_vs", 64'(vs), 64'(1));

    @(negedge vga_clk);
    reset_n = 1'b1;
    step();
    chk("first_xy", 64'({DrawX, DrawY}), 64'(20'd0));
    chk("first_blank", 64'(blank), 64'(1));
    chk("first_ls", 64'(line_start), 64'(1));
    chk("first_fs", 64'(frame_start), 64'(1));
    chk("first_fc", 64'(frame_count), 64'(1));
    fs_seen = 1;

    // ---------------- one full frame of statistics ----------------
    n_blank = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; first_vs = -1;
    for (int i = 0; i < FT; i++) begin
      if (blank) n_blank++;
      if (hs == HP) n_hs++;
      if (vs == VP) n_vs++;
      if (line_start) n_ls++;
      if (frame_start) n_fs++;
      if (vs == VP && first_vs < 0) first_vs = i;
      step();
    end
    fs_seen++;
    chk("frame_period", 64'(frame_start), 64'(1));
    chk("blank_count", 64'(n_blank), 64'(HV * VV));
    chk("hs_count", 64'(n_hs), 64'(HS * VT));
    chk("vs_count", 64'(n_vs), 64'(VS * HT));
    chk("ls_count", 64'(n_ls), 64'(VT));
    chk("fs_count", 64'(n_fs), 64'(1));
    chk("vs_offset", 64'(first_vs), 64'((VV + VF) * HT));

    // ---------------- wrap into vertical blanking ----------------
    guard = 0;
    while (!(DrawX == 10'(HT - 1) && DrawY == 10'(VV - 1)) && guard < 2 * FT) begin
      step(); guard++;
    end
    chk("wrap_vis_found", 64'(guard < 2 * FT), 64'(1));
    step();
    chk("wrap_vis_xy", 64'({DrawX, DrawY}), 64'({10'd0, 10'(VV)}));
    chk("wrap_vis_blank", 64'(blank), 64'(0));
    chk("wrap_vis_ls", 64'(line_start), 64'(1));
    chk("wrap_vis_fs", 64'(frame_start), 64'(0));

    // ---------------- frame wrap ----------------
    guard = 0;
    while (!(DrawX == 10'(HT - 1) && DrawY == 10'(VT - 1)) && guard < 2 * FT) begin
      step(); guard++;
    end
    chk("wrap_frm_found", 64'(guard < 2 * FT), 64'(1));
    step();
    fs_seen++;
    chk("wrap_frm_xy", 64'({DrawX, DrawY}), 64'(20'd0));
    chk("wrap_frm_fs", 64'(frame_start), 64'(1));

    // ---------------- frame_count wrap ----------------
    guard = 0;
    while (fs_seen < 256 && guard < 300 * FT) begin
      step(); guard++;
      if (frame_start) begin
        fs_seen++;
        if (fs_seen == 255) chk("fc_255", 64'(frame_count), 64'(255));
        if (fs_seen == 256) chk("fc_wrap", 64'(frame_count), 64'(0));
      end
    end
    chk("fc_reached", 64'(fs_seen), 64'(256));
    step();
    chk("fc_hold", 64'(frame_count), 64'(0));

    // ---------------- mid-frame asynchronous reset ----------------
    guard = 0;
    while (!(DrawX == 10'd5 && DrawY == 10'd3) && guard < 2 * FT) begin
      step(); guard++;
    end
    chk("mid_found", 64'(guard < 2 * FT), 64'(1));
    #2;                        // well away from either clock edge
    reset_n = 1'b0;
    #1;
    chk("mid_async", 64'(dut_o), 64'(reset_out()));
    model_reset();
    repeat (2) @(posedge vga_clk);
    #1;
    chk("mid_hold", 64'(dut_o), 64'(reset_out()));
    @(negedge vga_clk);
    reset_n = 1'b1;
    step();
    chk("mid_restart_xy", 64'({DrawX, DrawY}), 64'(20'd0));
    chk("mid_restart_fc", 64'(frame_count), 64'(1));
    chk("mid_restart_fs", 64'(frame_start), 64'(1));
    repeat (HT + 3) step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
